// File: rtl/pratica2_core_if.sv
// pratica2_core external bus: instruction/data inputs, debug and status outputs.
// master drives run/ir/din/dbg_sel, slave is the core.
interface pratica2_core_if;
  logic        run;
  logic [9:0]  ir;
  logic [15:0] din;
  logic [2:0]  dbg_sel;
  logic [15:0] q;
  logic [15:0] pc;
  logic [15:0] a_q;
  logic [15:0] g_q;
  logic [15:0] dbg_reg;
  logic        done;

  modport master (
    output run, ir, din, dbg_sel,
    input  q, pc, a_q, g_q, dbg_reg, done
  );

  modport slave (
    input  run, ir, din, dbg_sel,
    output q, pc, a_q, g_q, dbg_reg, done
  );
endinterface

// File: rtl/pratica2_core.sv
// pratica2_core: multicycle 16-bit core with R0-R7 (R7 = pc), A, G,
// one-hot bus mux, add/sub/compare unit and a T0-T3 control FSM.
module pratica2_core (
  input  logic clock,
  input  logic resetn,
  pratica2_core_if.slave bus
);

  typedef enum logic [1:0] {T0, T1, T2, T3} state_t;

  localparam logic [3:0] OP_MV   = 4'd0;
  localparam logic [3:0] OP_MVI  = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_SLT  = 4'd4;
  localparam logic [3:0] OP_SEQ  = 4'd5;
  localparam logic [3:0] OP_MVNZ = 4'd6;

  state_t      r_state;
  logic [9:0]  r_ir;
  logic        r_done;
  logic [15:0] r_regs [8];
  logic [15:0] r_a;
  logic [15:0] r_g;

  logic [3:0]  w_op;
  logic [2:0]  w_x;
  logic [2:0]  w_y;
  logic        w_din_out;
  logic        w_g_out;
  logic [7:0]  w_r_out;
  logic        w_rx_in;
  logic        w_a_in;
  logic        w_g_in;
  logic        w_zero;
  logic [15:0] w_bus;
  logic [15:0] w_alu;

  function automatic logic f_alu(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_SEQ);
  endfunction

  assign w_op   = r_ir[9:6];
  assign w_x    = r_ir[5:3];
  assign w_y    = r_ir[2:0];
  assign w_zero = (r_g == 16'h0000);

  always_ff @(posedge clock or posedge resetn) begin
    if (resetn) begin
      r_state <= T0;
      r_ir    <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        T0: begin
          if (bus.run) begin
            r_ir    <= bus.ir;
            r_state <= T1;
            // short ops finish in T1, so done is raised on entry
            r_done  <= !f_alu(bus.ir[9:6]);
          end
        end
        T1: r_state <= f_alu(w_op) ? T2 : T0;
        T2: begin
          r_state <= T3;
          r_done  <= 1'b1;
        end
        T3: r_state <= T0;
        default: r_state <= T0;
      endcase
    end
  end

  always_comb begin
    w_din_out = 1'b0;
    w_g_out   = 1'b0;
    w_r_out   = '0;
    w_rx_in   = 1'b0;
    w_a_in    = 1'b0;
    w_g_in    = 1'b0;
    unique case (r_state)
      T1: begin
        unique case (1'b1)
          (w_op == OP_MV): begin
            w_r_out[w_y] = 1'b1;
            w_rx_in      = 1'b1;
          end
          (w_op == OP_MVI): begin
            w_din_out = 1'b1;
            w_rx_in   = 1'b1;
          end
          (w_op == OP_MVNZ): begin
            w_r_out[w_y] = !w_zero;
            w_rx_in      = !w_zero;
          end
          f_alu(w_op): begin
            w_r_out[w_x] = 1'b1;
            w_a_in       = 1'b1;
          end
          default: ;
        endcase
      end
      T2: begin
        w_r_out[w_y] = 1'b1;
        w_g_in       = 1'b1;
      end
      T3: begin
        w_g_out = 1'b1;
        w_rx_in = 1'b1;
      end
      default: ;
    endcase
  end

  // priority: din, then G, then R0..R7
  always_comb begin
    w_bus = '0;
    for (int i = 7; i >= 0; i--) begin
      if (w_r_out[i]) w_bus = r_regs[i];
    end
    if (w_g_out)   w_bus = r_g;
    if (w_din_out) w_bus = bus.din;
  end

  always_comb begin
    w_alu = r_g;
    unique case (w_op)
      OP_ADD:  w_alu = r_a + w_bus;
      OP_SUB:  w_alu = r_a - w_bus;
      OP_SLT:  w_alu = {15'b0, r_a < w_bus};
      OP_SEQ:  w_alu = {15'b0, r_a == w_bus};
      default: w_alu = r_g;
    endcase
  end

  always_ff @(posedge clock or posedge resetn) begin
    if (resetn) begin
      for (int i = 0; i < 8; i++) r_regs[i] <= '0;
      r_a <= '0;
      r_g <= '0;
    end else begin
      if (w_a_in) r_a <= w_bus;
      if (w_g_in) r_g <= w_alu;
      if (w_rx_in) r_regs[w_x] <= w_bus;
      // an explicit write to R7 overrides the increment
      if (r_done && !(w_rx_in && (w_x == 3'd7)))
        r_regs[7] <= r_regs[7] + 16'd1;
    end
  end

  assign bus.q       = w_bus;
  assign bus.pc      = r_regs[7];
  assign bus.a_q     = r_a;
  assign bus.g_q     = r_g;
  assign bus.dbg_reg = r_regs[bus.dbg_sel];
  assign bus.done    = r_done;

endmodule

// File: tb/tb_pratica2_core.sv
// Testbench for pratica2_core: directed program plus random instructions
// checked against an instruction-level reference model.
module tb_pratica2_core;

  logic clock = 1'b0;
  logic resetn = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  logic [15:0] m_r [8];
  logic [15:0] m_a;
  logic [15:0] m_g;

  pratica2_core_if bus ();

  pratica2_core dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  always #10 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic rd(input int i, output logic [15:0] v);
    bus.dbg_sel = 3'(i);
    #1 v = bus.dbg_reg;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_r[i] = '0;
    m_a = '0;
    m_g = '0;
  endtask

  task automatic chk_model(input string tag);
    logic [15:0] v;
    for (int i = 0; i < 8; i++) begin
      rd(i, v);
      chk($sformatf("%s_r%0d", tag, i), v, m_r[i]);
    end
    chk({tag, "_a"}, bus.a_q, m_a);
    chk({tag, "_g"}, bus.g_q, m_g);
    chk({tag, "_pc"}, bus.pc, m_r[7]);
  endtask

  task automatic model_exec(input logic [3:0] op, input logic [2:0] x,
                            input logic [2:0] y, input logic [15:0] d);
    logic [15:0] rx, ry;
    bit wr;
    rx = m_r[x];
    ry = m_r[y];
    wr = 1'b0;
    case (op)
      4'd0: begin m_r[x] = ry; wr = 1; end
      4'd1: begin m_r[x] = d; wr = 1; end
      4'd2: begin m_a = rx; m_g = rx + ry; m_r[x] = m_g; wr = 1; end
      4'd3: begin m_a = rx; m_g = rx - ry; m_r[x] = m_g; wr = 1; end
      4'd4: begin m_a = rx; m_g = (rx < ry) ? 16'd1 : 16'd0;
                  m_r[x] = m_g; wr = 1; end
      4'd5: begin m_a = rx; m_g = (rx == ry) ? 16'd1 : 16'd0;
                  m_r[x] = m_g; wr = 1; end
      4'd6: if (m_g != 0) begin m_r[x] = ry; wr = 1; end
      default: ;
    endcase
    if (!(wr && x == 3'd7)) m_r[7] = m_r[7] + 16'd1;
  endtask

  task automatic exec(input logic [3:0] op, input logic [2:0] x,
                      input logic [2:0] y, input logic [15:0] d);
    int lat;
    bit alu;
    alu = (op >= 4'd2) && (op <= 4'd5);
    @(negedge clock);
    bus.ir  = {op, x, y};
    bus.din = d;
    bus.run = 1'b1;
    @(posedge clock);
    #1 bus.run = 1'b0;
    lat = 1;
    while (!bus.done && lat < 8) begin
      @(posedge clock);
      #1 lat++;
    end
    chk($sformatf("lat_op%0d", op), lat, alu ? 3 : 1);
    if (op == 4'd1) chk("q_mvi", bus.q, d);
    @(posedge clock);
    #1 chk("done_clr", bus.done, 1'b0);
    model_exec(op, x, y, d);
    chk_model($sformatf("op%0d", op));
  endtask

  initial begin
    logic [15:0] v;
    bus.run = 1'b0;
    bus.ir = '0;
    bus.din = '0;
    bus.dbg_sel = '0;
    model_reset();

    repeat (2) @(posedge clock);
    #1 resetn = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_pc", bus.pc, 16'd0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_q", bus.q, 16'd0);
    chk_model("rst");

    exec(4'd1, 3'd0, 3'd0, 16'h0005);
    rd(0, v); chk("mvi_r0", v, 16'h0005);
    chk("mvi_pc", bus.pc, 16'd1);
    exec(4'd0, 3'd1, 3'd0, 16'h1234);
    rd(1, v); chk("mv_r1", v, 16'h0005);
    chk("mv_pc", bus.pc, 16'd2);
    exec(4'd2, 3'd0, 3'd1, 16'h0);
    rd(0, v); chk("add_r0", v, 16'h000A);
    chk("add_g", bus.g_q, 16'h000A);
    chk("add_a", bus.a_q, 16'h0005);
    exec(4'd3, 3'd1, 3'd0, 16'h0);
    rd(1, v); chk("sub_wrap", v, 16'hFFFB);
    exec(4'd4, 3'd2, 3'd1, 16'h0);
    rd(2, v); chk("slt_r2", v, 16'h0001);
    exec(4'd5, 3'd3, 3'd3, 16'h0);
    rd(3, v); chk("seq_r3", v, 16'h0001);
    exec(4'd3, 3'd5, 3'd5, 16'h0);
    chk("g_zero", bus.g_q, 16'h0000);
    exec(4'd6, 3'd4, 3'd0, 16'h0);
    rd(4, v); chk("mvnz_hold", v, 16'h0000);
    exec(4'd5, 3'd3, 3'd3, 16'h0);
    exec(4'd6, 3'd4, 3'd0, 16'h0);
    rd(4, v); chk("mvnz_move", v, 16'h000A);
    exec(4'd9, 3'd2, 3'd2, 16'h0);
    exec(4'd1, 3'd7, 3'd0, 16'h0003);
    chk("pc_write", bus.pc, 16'd3);

    // abort an add in T2 with an asynchronous reset
    @(negedge clock);
    bus.ir  = {4'd2, 3'd0, 3'd1};
    bus.run = 1'b1;
    @(posedge clock);
    #1 bus.run = 1'b0;
    @(posedge clock);
    #3 resetn = 1'b1;
    #1;
    model_reset();
    chk("abort_pc", bus.pc, 16'd0);
    chk("abort_done", bus.done, 1'b0);
    chk_model("abort");
    @(negedge clock);
    resetn = 1'b0;
    exec(4'd1, 3'd6, 3'd0, 16'hBEEF);

    for (int k = 0; k < 300; k++) begin
      exec(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
           3'($urandom_range(0, 7)), 16'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
